prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 34 +++
 rtl/prog_loader_byte_packer.sv | 54 +++++
 rtl/prog_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared rv32i loader parameters (FSM encodings, header and word sizes, capacity helper).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds the CSUM state encoding.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package prog_loader_pkg;

  // Loader states. CSUM only exists when the trailing checksum byte is enabled.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
    ST_CSUM = 3'd3,
`endif
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  // Length header is a 4-byte little-endian word count.
  localparam int unsigned LEN_BYTES  = 4;
  // Every payload word is 4 little-endian bytes.
  localparam int unsigned WORD_BYTES = 4;

  // Largest word count that fits a BRAM of 2^aw bytes.
  function automatic int unsigned max_words(input int unsigned aw);
    return (32'd1 << aw) / WORD_BYTES;
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: gathers little-endian bytes into a word (2-bit lane index + right-shifting register).
// Latency: combinational word_o/last_o on the byte that completes a word; lane state updates next edge.
// Backpressure: none; the caller only asserts en_i for bytes it has actually accepted.
// Ports: clk/rst (sync, active-high), clr_i restarts at lane 0, en_i+data_i one accepted byte,
//        last_o marks the completing byte, word_o is the assembled word including data_i.

module byte_packer
  import prog_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic [7:0]                data_i,
  output logic                      last_o,
  output logic [8*WORD_BYTES-1:0]   word_o
);

  localparam int LANE_W = $clog2(WORD_BYTES);
  localparam int WORD_W = 8 * WORD_BYTES;

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;

  // New bytes enter at the top and slide down, so after WORD_BYTES bytes the
  // first byte received sits in bits [7:0] (little-endian).
  always_comb begin
    lane_d  = lane_q;
    shreg_d = shreg_q;
    if (clr_i) begin
      lane_d  = '0;
      shreg_d = '0;
    end else if (en_i) begin
      lane_d  = lane_q + 1'b1;
      shreg_d = {data_i, shreg_q[WORD_W-1:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      shreg_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shreg_q <= shreg_d;
    end
  end

  // Word is presented on the completing byte so the caller can register it
  // without an extra pipeline stage.
  assign last_o = en_i && !clr_i && (lane_q == LANE_W'(WORD_BYTES - 1));
  assign word_o = {data_i, shreg_q[WORD_W-1:8]};

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed boot image into instruction BRAM while holding the CPU stalled.
// Latency: BRAM write pulses one cycle after the 4th byte of each word; one byte per clock sustained.
// Backpressure: in_ready high only in LEN/DATA/CSUM; bytes offered at other times are left untouched.
// Ports: clk, rst (sync active-high), start (one-cycle load request), in_valid/in_data/in_ready (byte stream),
//        w_addr/w_dat/w_enb (BRAM write port), cpu_stall, done, error, words_loaded (words written this load).
// Optional feature macro: PROG_LOADER_CHECKSUM_EN -- trailing XOR checksum byte verified in CSUM.

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_dat,
  output logic                  w_enb,
  output logic                  cpu_stall,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-2:0] words_loaded
);

  localparam int          WL_W      = ADDR_WIDTH - 1;
  localparam int          WORD_W    = 8 * WORD_BYTES;
  localparam logic [31:0] MAX_WORDS = 32'(max_words(ADDR_WIDTH));

  state_e state_q, state_d;

  logic              accept;
  logic              pk_en;
  logic              pk_last;
  logic [WORD_W-1:0] pk_word;
  logic              go_len;
  logic              last_word;
  logic              len_bad;

  logic [WL_W-1:0]       len_q;
  logic [WL_W-1:0]       words_loaded_q;
  logic                  w_enb_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [DATA_WIDTH-1:0] w_dat_q;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
`endif

  assign accept = in_valid && in_ready;

  // One packer serves both the length header and the payload: both are
  // 4-byte little-endian quantities and never overlap in time.
  assign pk_en = accept && ((state_q == ST_LEN) || (state_q == ST_DATA));

  byte_packer u_byte_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (go_len),
    .en_i   (pk_en),
    .data_i (in_data),
    .last_o (pk_last),
    .word_o (pk_word)
  );

  // Reject empty images and anything that would run past the top of BRAM;
  // this is what guarantees w_addr never wraps.
  assign len_bad = (pk_word == '0) || (pk_word > MAX_WORDS);

  // words_loaded_q doubles as the index of the word now completing.
  assign last_word = ((words_loaded_q + 1'b1) == len_q);

  // A fresh load starts from IDLE, DONE or ERR; start is ignored mid-load.
  assign go_len = (state_d == ST_LEN) && (state_q != ST_LEN);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (pk_last) state_d = len_bad ? ST_ERR : ST_DATA;
      end
      ST_DATA: begin
        if (pk_last && last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE: begin
        if (start) state_d = ST_LEN;
      end
      ST_ERR: begin
        if (start) state_d = ST_LEN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    cpu_stall = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state_q)
      ST_LEN:  in_ready = 1'b1;
      ST_DATA: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CSUM: in_ready = 1'b1;
`endif
      ST_DONE: begin
        cpu_stall = 1'b0;
        done      = 1'b1;
      end
      ST_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: length capture, BRAM write port, word counter, checksum
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q          <= '0;
      words_loaded_q <= '0;
      w_enb_q        <= 1'b0;
      w_addr_q       <= '0;
      w_dat_q        <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q         <= '0;
`endif
    end else begin
      // Write enable is a single-cycle pulse per completed word.
      w_enb_q <= 1'b0;

      if (go_len) begin
        words_loaded_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_q         <= '0;
`endif
      end

      // Only the low bits matter: oversized lengths divert to ERR anyway.
      if ((state_q == ST_LEN) && pk_last) begin
        len_q <= pk_word[WL_W-1:0];
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      if ((state_q == ST_DATA) && accept) begin
        csum_q <= csum_q ^ in_data;
      end
`endif

      // Register the completed word; the packer keeps accepting the next
      // word's first byte in the same cycle the write is issued.
      if ((state_q == ST_DATA) && pk_last) begin
        w_enb_q        <= 1'b1;
        w_addr_q       <= {words_loaded_q[ADDR_WIDTH-3:0], 2'b00};
        w_dat_q        <= DATA_WIDTH'(pk_word);
        words_loaded_q <= words_loaded_q + 1'b1;
      end
    end
  end

  assign w_enb        = w_enb_q;
  assign w_addr       = w_addr_q;
  assign w_dat        = w_dat_q;
  assign words_loaded = words_loaded_q;

endmodule
